// File: rtl/fsmc_buf_arbiter_if.sv
// Bundles the FSMC host strobes, the local req/gnt port and the buffer RAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fsmc_buf_arbiter_if #(
  parameter int AW = 9
);
  logic          host_rd;
  logic          host_wr;
  logic          host_idx_wr;
  logic [15:0]   host_wdata;
  logic [15:0]   host_rdata;
  logic          host_rvalid;
  logic [AW-1:0] host_index;
  logic          host_ovr;

  logic          loc_req;
  logic          loc_we;
  logic [AW-1:0] loc_addr;
  logic [15:0]   loc_wdata;
  logic          loc_gnt;
  logic [15:0]   loc_rdata;
  logic          loc_rvalid;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;

  modport slave (
    input  host_rd, host_wr, host_idx_wr, host_wdata,
    output host_rdata, host_rvalid, host_index, host_ovr,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output loc_gnt, loc_rdata, loc_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output host_rd, host_wr, host_idx_wr, host_wdata,
    input  host_rdata, host_rvalid, host_index, host_ovr,
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  loc_gnt, loc_rdata, loc_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/fsmc_buf_arbiter.sv
// Single-port buffer RAM arbiter: FSMC host (auto-increment index) has priority over one local requester.
// Define FSMC_STARVE_GUARD_EN to add the local-starvation guard (forced local slot plus 1-deep host pend slot).
module fsmc_buf_arbiter #(
  parameter int DEPTH    = 512,
  parameter int AW       = 9,
  parameter int MAX_WAIT = 7
) (
  input  logic                clk,
  input  logic                reset,
  fsmc_buf_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_IDX} op_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_HOST, TAG_LOC}    tag_e;

  if (DEPTH != (1 << AW) || MAX_WAIT < 1) begin : g_param_check
    $error("fsmc_buf_arbiter: DEPTH must be 2**AW and MAX_WAIT must be at least 1");
  end

  op_e           new_op, exec_op;
  logic          strobe_clash;
  logic [15:0]   exec_data;
  logic          loc_gnt_c;
  logic          ram_en_c, ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [15:0]   ram_wdata_c;
  logic [AW-1:0] index_inc;

  logic [AW-1:0] index_q, index_d;
  logic [15:0]   host_rdata_q, host_rdata_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic          host_ovr_q, host_ovr_d;
  logic [15:0]   loc_rdata_q, loc_rdata_d;
  tag_e          rd_tag_q, rd_tag_d;

`ifdef FSMC_STARVE_GUARD_EN
  typedef enum logic {ST_RUN, ST_FORCE} state_e;
  localparam int WCW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic          pend_vld_q, pend_vld_d;
  op_e           pend_op_q, pend_op_d;
  logic [15:0]   pend_data_q, pend_data_d;
`endif

  // Index load beats rd/wr, and wr beats rd; any loser is a dropped strobe.
  always_comb begin
    new_op       = OP_NONE;
    strobe_clash = 1'b0;
    if (bus.host_idx_wr) begin
      new_op       = OP_IDX;
      strobe_clash = bus.host_rd | bus.host_wr;
    end else if (bus.host_wr) begin
      new_op       = OP_WR;
      strobe_clash = bus.host_rd;
    end else if (bus.host_rd) begin
      new_op       = OP_RD;
    end
  end

  assign index_inc = (index_q == AW'(DEPTH - 1)) ? '0 : index_q + 1'b1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    exec_op    = OP_NONE;
    exec_data  = bus.host_wdata;
    loc_gnt_c  = 1'b0;
    host_ovr_d = host_ovr_q | strobe_clash;

`ifdef FSMC_STARVE_GUARD_EN
    state_d     = ST_RUN;
    wait_cnt_d  = wait_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_op_d   = pend_op_q;
    pend_data_d = pend_data_q;

    if (state_q == ST_FORCE) begin
      // Forced local slot: the host op is parked, or lost if the park slot is still occupied.
      loc_gnt_c = bus.loc_req;
      if (new_op != OP_NONE) begin
        if (pend_vld_q) begin
          host_ovr_d = 1'b1;
        end else begin
          pend_vld_d  = 1'b1;
          pend_op_d   = new_op;
          pend_data_d = bus.host_wdata;
        end
      end
    end else begin
      if (pend_vld_q) begin
        exec_op     = pend_op_q;
        exec_data   = pend_data_q;
        pend_vld_d  = (new_op != OP_NONE);
        pend_op_d   = new_op;
        pend_data_d = bus.host_wdata;
      end else begin
        exec_op = new_op;
      end
      loc_gnt_c = bus.loc_req && !(exec_op inside {OP_RD, OP_WR});
    end

    if (loc_gnt_c) begin
      wait_cnt_d = '0;
    end else if (bus.loc_req && wait_cnt_q != WCW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (state_q == ST_RUN && !loc_gnt_c && wait_cnt_d == WCW'(MAX_WAIT)) begin
      state_d = ST_FORCE;
    end
`else
    exec_op   = new_op;
    loc_gnt_c = bus.loc_req && !(exec_op inside {OP_RD, OP_WR});
`endif

    if (reset) begin
      loc_gnt_c = 1'b0;
    end

    index_d  = index_q;
    rd_tag_d = TAG_NONE;
    case (exec_op)
      OP_IDX:  index_d = exec_data[AW-1:0];
      OP_RD: begin
        index_d  = index_inc;
        rd_tag_d = TAG_HOST;
      end
      OP_WR:   index_d = index_inc;
      default: ;
    endcase
    if (loc_gnt_c && !bus.loc_we) begin
      rd_tag_d = TAG_LOC;
    end

    // Data of a read issued last cycle is on ram_rdata now; route it to its owner.
    host_rvalid_d = (rd_tag_q == TAG_HOST);
    host_rdata_d  = (rd_tag_q == TAG_HOST) ? bus.ram_rdata : host_rdata_q;
    loc_rdata_d   = (rd_tag_q == TAG_LOC)  ? bus.ram_rdata : loc_rdata_q;

    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    if (exec_op inside {OP_RD, OP_WR}) begin
      ram_en_c    = 1'b1;
      ram_we_c    = (exec_op == OP_WR);
      ram_addr_c  = index_q;
      ram_wdata_c = exec_data;
    end else if (loc_gnt_c) begin
      ram_en_c    = 1'b1;
      ram_we_c    = bus.loc_we;
      ram_addr_c  = bus.loc_addr;
      ram_wdata_c = bus.loc_wdata;
    end
    if (reset) begin
      ram_en_c = 1'b0;
      ram_we_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      index_q       <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_ovr_q    <= 1'b0;
      loc_rdata_q   <= '0;
      rd_tag_q      <= TAG_NONE;
`ifdef FSMC_STARVE_GUARD_EN
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      pend_vld_q    <= 1'b0;
      pend_op_q     <= OP_NONE;
      pend_data_q   <= '0;
`endif
    end else begin
      index_q       <= index_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      host_ovr_q    <= host_ovr_d;
      loc_rdata_q   <= loc_rdata_d;
      rd_tag_q      <= rd_tag_d;
`ifdef FSMC_STARVE_GUARD_EN
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pend_vld_q    <= pend_vld_d;
      pend_op_q     <= pend_op_d;
      pend_data_q   <= pend_data_d;
`endif
    end
  end

  logic loc_rvalid_c;
  assign loc_rvalid_c = (rd_tag_q == TAG_LOC) && !reset;

  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_index  = index_q;
  assign bus.host_ovr    = host_ovr_q;
  assign bus.loc_gnt     = loc_gnt_c;
  assign bus.loc_rvalid  = loc_rvalid_c;
  assign bus.loc_rdata   = loc_rvalid_c ? bus.ram_rdata : loc_rdata_q;
  assign bus.ram_en      = ram_en_c;
  assign bus.ram_we      = ram_we_c;
  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_wdata   = ram_wdata_c;

endmodule

// File: tb/tb_fsmc_buf_arbiter.sv
// Scoreboard bench for fsmc_buf_arbiter: directed host/local traffic against a 1-cycle-latency RAM model.
// Expected read data and arrival cycle are queued at issue; a negedge monitor pops on each rvalid.
module tb_fsmc_buf_arbiter;
  localparam int AW       = 9;
  localparam int DEPTH    = 512;
  localparam int MAX_WAIT = 7;
`ifdef FSMC_STARVE_GUARD_EN
  localparam bit GUARD  = 1'b1;
  localparam int T4_GNT = MAX_WAIT + 1;
`else
  localparam bit GUARD  = 1'b0;
  localparam int T4_GNT = 21;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsmc_buf_arbiter_if #(.AW(AW)) bus ();

  fsmc_buf_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t host_q[$];
  exp_t loc_q[$];
  exp_t h_e, l_e;

  always @(negedge clk) begin
    if (bus.host_rvalid) begin
      if (host_q.size() == 0) begin
        check("host_rvalid_unexpected", 32'(bus.host_rvalid), 32'd0);
      end else begin
        h_e = host_q.pop_front();
        check("host_rdata", 32'(bus.host_rdata), 32'(h_e.data));
        check("host_latency_cycle", 32'(cyc), 32'(h_e.due));
      end
    end
    if (bus.loc_rvalid) begin
      if (loc_q.size() == 0) begin
        check("loc_rvalid_unexpected", 32'(bus.loc_rvalid), 32'd0);
      end else begin
        l_e = loc_q.pop_front();
        check("loc_rdata", 32'(bus.loc_rdata), 32'(l_e.data));
        check("loc_latency_cycle", 32'(cyc), 32'(l_e.due));
      end
    end
  end

  // Every stimulus task starts and ends 1 time unit after a rising edge.
  task automatic host_cycle(input logic rd, input logic wr, input logic idx, input logic [15:0] d);
    bus.host_rd     = rd;
    bus.host_wr     = wr;
    bus.host_idx_wr = idx;
    bus.host_wdata  = d;
    @(posedge clk); #1;
    bus.host_rd     = 1'b0;
    bus.host_wr     = 1'b0;
    bus.host_idx_wr = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] exp_d);
    host_q.push_back('{exp_d, cyc + 2});
    host_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic loc_op(input logic we, input logic [AW-1:0] a, input logic [15:0] d, input string name);
    logic got = 1'b0;
    bus.loc_req   = 1'b1;
    bus.loc_we    = we;
    bus.loc_addr  = a;
    bus.loc_wdata = d;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.loc_gnt) begin
        got = 1'b1;
        if (!we) loc_q.push_back('{d, cyc + 1});
      end
      @(posedge clk); #1;
    end
    bus.loc_req = 1'b0;
    check(name, 32'(got), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_host_rdata"},  32'(bus.host_rdata),  32'd0);
    check({tag, "_host_rvalid"}, 32'(bus.host_rvalid), 32'd0);
    check({tag, "_host_index"},  32'(bus.host_index),  32'd0);
    check({tag, "_host_ovr"},    32'(bus.host_ovr),    32'd0);
    check({tag, "_loc_rvalid"},  32'(bus.loc_rvalid),  32'd0);
    check({tag, "_loc_rdata"},   32'(bus.loc_rdata),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int gnt_at;

  initial begin
    reset           = 1'b1;
    bus.host_rd     = 1'b0;
    bus.host_wr     = 1'b1;
    bus.host_idx_wr = 1'b0;
    bus.host_wdata  = 16'hDEAD;
    bus.loc_req     = 1'b1;
    bus.loc_we      = 1'b0;
    bus.loc_addr    = '0;
    bus.loc_wdata   = 16'h0000;

    // Reset with requests pending: no grant, no RAM strobe.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_loc_gnt", 32'(bus.loc_gnt), 32'd0);
    check("rst_ram_en",  32'(bus.ram_en),  32'd0);
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.host_wr = 1'b0;
    bus.loc_req = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;

    // T1: writes at 0x005/0x006, read back, index ends at 0x007.
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0005);
    host_cycle(1'b0, 1'b1, 1'b0, 16'hA5A5);
    host_cycle(1'b0, 1'b1, 1'b0, 16'h1234);
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0005);
    host_read(16'hA5A5);
    host_read(16'h1234);
    idle(3);
    check("t1_index", 32'(bus.host_index), 32'h007);
    check("t1_ovr",   32'(bus.host_ovr),   32'd0);

    // T2: index wraps 0x1FF -> 0x000 -> 0x001.
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    host_cycle(1'b0, 1'b1, 1'b0, 16'h0F0F);
    host_cycle(1'b0, 1'b0, 1'b1, 16'h01FF);
    check("t2_index_load", 32'(bus.host_index), 32'h1FF);
    host_cycle(1'b0, 1'b1, 1'b0, 16'hBEEF);
    check("t2_index_wrap", 32'(bus.host_index), 32'h000);
    host_read(16'h0F0F);
    check("t2_index_after_rd", 32'(bus.host_index), 32'h001);
    host_cycle(1'b0, 1'b0, 1'b1, 16'h01FF);
    host_read(16'hBEEF);
    idle(3);

    // T3: local write collides with host write (index 0); host wins, local next cycle.
    bus.loc_req     = 1'b1;
    bus.loc_we      = 1'b1;
    bus.loc_addr    = 9'h010;
    bus.loc_wdata   = 16'h5555;
    bus.host_wr     = 1'b1;
    bus.host_wdata  = 16'h7777;
    @(negedge clk);
    check("t3_host_wins", 32'(bus.loc_gnt), 32'd0);
    @(posedge clk); #1;
    bus.host_wr = 1'b0;
    @(negedge clk);
    check("t3_loc_gnt_next", 32'(bus.loc_gnt), 32'd1);
    @(posedge clk); #1;
    bus.loc_req = 1'b0;
    loc_op(1'b0, 9'h010, 16'h5555, "t3_loc_rd_gnt");
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    host_read(16'h7777);
    idle(3);

    // T4: host reads every cycle for 20 clk while local read request is held.
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0100);
    for (int i = 0; i < 20; i++) host_cycle(1'b0, 1'b1, 1'b0, 16'(32'h3000 + i));
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0100);
    gnt_at       = 0;
    bus.loc_req  = 1'b1;
    bus.loc_we   = 1'b0;
    bus.loc_addr = 9'h010;
    for (int i = 1; i <= 20; i++) begin
      host_q.push_back('{16'(32'h3000 + i - 1), cyc + ((GUARD && i >= T4_GNT) ? 3 : 2)});
      bus.host_rd = 1'b1;
      @(negedge clk);
      if (gnt_at == 0 && bus.loc_gnt) begin
        gnt_at = i;
        loc_q.push_back('{16'h5555, cyc + 1});
      end
      @(posedge clk); #1;
      if (gnt_at == i) bus.loc_req = 1'b0;
    end
    bus.host_rd = 1'b0;
    for (int k = 1; k <= 10 && gnt_at == 0; k++) begin
      @(negedge clk);
      if (bus.loc_gnt) begin
        gnt_at = 20 + k;
        loc_q.push_back('{16'h5555, cyc + 1});
      end
      @(posedge clk); #1;
    end
    bus.loc_req = 1'b0;
    check("t4_gnt_cycle", 32'(gnt_at), 32'(T4_GNT));
    idle(4);
    check("t4_ovr", 32'(bus.host_ovr), 32'd0);
    check("t4_host_drained", 32'(host_q.size()), 32'd0);
    check("t4_index", 32'(bus.host_index), 32'h114);

    // T5: rd+wr together -> write only, sticky overrun; idx_wr+rd -> load only.
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0020);
    host_cycle(1'b1, 1'b1, 1'b0, 16'h6666);
    idle(3);
    check("t5_ovr_set", 32'(bus.host_ovr),   32'd1);
    check("t5_index",   32'(bus.host_index), 32'h021);
    host_cycle(1'b0, 1'b0, 1'b1, 16'h0020);
    host_read(16'h6666);
    host_cycle(1'b1, 1'b0, 1'b1, 16'h0040);
    idle(3);
    check("t5_idx_wins", 32'(bus.host_index), 32'h040);
    check("t5_ovr_sticky", 32'(bus.host_ovr), 32'd1);

    // T6: reset the cycle after a granted local read; the read is discarded.
    bus.loc_req  = 1'b1;
    bus.loc_we   = 1'b0;
    bus.loc_addr = 9'h010;
    @(negedge clk);
    check("t6_loc_gnt", 32'(bus.loc_gnt), 32'd1);
    @(posedge clk); #1;
    bus.loc_req = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    check("t6_no_loc_rvalid", 32'(bus.loc_rvalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("t6");
    @(posedge clk); #1;
    idle(3);

    check("end_host_q_empty", 32'(host_q.size()), 32'd0);
    check("end_loc_q_empty",  32'(loc_q.size()),  32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
